// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Display stage of the stopwatch: scans four BCD digits (MM:SS) onto a
//   4-digit multiplexed 7-segment display with active-low anodes/cathodes.
//   Digit inputs are double-buffered (shadow -> display) and committed only
//   at frame boundaries. Anodes are blanked for GHOST_CYCLES at the start of
//   every digit slot. The field selected by adj_state blinks.
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   min_tens   BCD digit 3 (leftmost)
//   min_ones   BCD digit 2
//   sec_tens   BCD digit 1
//   sec_ones   BCD digit 0 (rightmost)
//   upd        1-cycle strobe: capture the four digits into the shadow register
//   adj_state  00 none, 01 minutes blink, 10 seconds blink, 11 as 00
//   AN         anode enables, active-low, AN[i] selects digit i (registered)
//   CA..CG     segment cathodes a..g, active-low (registered)
module seg_scan_driver #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned GHOST_CYCLES = 1000,
    parameter int unsigned BLINK_DIV    = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] min_tens,
    input  logic [3:0] min_ones,
    input  logic [3:0] sec_tens,
    input  logic [3:0] sec_ones,
    input  logic       upd,
    input  logic [1:0] adj_state,
    output logic [3:0] AN,
    output logic       CA,
    output logic       CB,
    output logic       CC,
    output logic       CD,
    output logic       CE,
    output logic       CF,
    output logic       CG
);

    localparam int unsigned SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SW-1:0] SLOT_LAST  = SW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [SW-1:0] slot_q, slot_d;
    logic [1:0]    idx_q, idx_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_ph_q, blink_ph_d;
    logic [1:0]    adj_q;
    logic [3:0]    shadow_q [4];
    logic [3:0]    disp_q   [4];
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;

    logic          slot_wrap;
    logic          restart;
    logic          in_field;
    logic          in_ghost;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h01;
            4'd1:    decode = 7'h4F;
            4'd2:    decode = 7'h12;
            4'd3:    decode = 7'h06;
            4'd4:    decode = 7'h4C;
            4'd5:    decode = 7'h24;
            4'd6:    decode = 7'h20;
            4'd7:    decode = 7'h0F;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h04;
            default: decode = 7'h7F;
        endcase
    endfunction

    // GHOST_CYCLES = 0 would make the slot comparison constant-false.
    generate
        if (GHOST_CYCLES == 0) begin : g_no_ghost
            assign in_ghost = 1'b0;
        end else begin : g_ghost
            assign in_ghost = (slot_q < SW'(GHOST_CYCLES));
        end
    endgenerate

    always_comb begin
        slot_wrap = (slot_q == SLOT_LAST);
        slot_d    = slot_wrap ? '0 : slot_q + 1'b1;
        idx_d     = slot_wrap ? idx_q + 2'd1 : idx_q;

        restart = (adj_state != adj_q);
        if (restart) begin
            blink_cnt_d = '0;
            blink_ph_d  = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
            blink_ph_d  = blink_ph_q;
        end

        in_field = ((adj_state == 2'b01) && idx_q[1]) ||
                   ((adj_state == 2'b10) && !idx_q[1]);

        if (in_ghost) begin
            an_d  = '1;
            seg_d = '1;
        end else begin
            an_d = ~(4'b0001 << idx_q);
            // A pending restart suppresses blanking so a newly selected
            // field is visible on the very next cycle.
            if (blink_ph_q && !restart && in_field) begin
                seg_d = '1;
            end else begin
                seg_d = decode(disp_q[idx_q]);
            end
        end
    end

    always_ff @(posedge clk) begin
        adj_q <= adj_state;
        if (reset) begin
            slot_q      <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            an_q        <= '1;
            seg_q       <= '1;
            for (int unsigned i = 0; i < 4; i++) begin
                shadow_q[i] <= '0;
                disp_q[i]   <= '0;
            end
        end else begin
            slot_q      <= slot_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            // Commit reads the pre-edge shadow, so a coincident upd lands next frame.
            if (slot_wrap && idx_q == 2'd3) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    disp_q[i] <= shadow_q[i];
                end
            end
            if (upd) begin
                shadow_q[3] <= min_tens;
                shadow_q[2] <= min_ones;
                shadow_q[1] <= sec_tens;
                shadow_q[0] <= sec_ones;
            end
        end
    end

    assign AN = an_q;
    assign {CA, CB, CC, CD, CE, CF, CG} = seg_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

    localparam int R = 8;
    localparam int G = 2;
    localparam int B = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       upd;
    logic [1:0] adj_state;
    logic [3:0] an1, an2;
    logic [6:0] seg1, seg2;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    seg_scan_driver #(.REFRESH_DIV(R), .GHOST_CYCLES(G), .BLINK_DIV(B)) dut (
        .clk(clk), .reset(reset),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .upd(upd), .adj_state(adj_state), .AN(an1),
        .CA(seg1[6]), .CB(seg1[5]), .CC(seg1[4]), .CD(seg1[3]),
        .CE(seg1[2]), .CF(seg1[1]), .CG(seg1[0])
    );

    seg_scan_driver #(.REFRESH_DIV(R), .GHOST_CYCLES(0), .BLINK_DIV(B)) dut_ng (
        .clk(clk), .reset(reset),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .upd(upd), .adj_state(adj_state), .AN(an2),
        .CA(seg2[6]), .CB(seg2[5]), .CC(seg2[4]), .CD(seg2[3]),
        .CE(seg2[2]), .CF(seg2[1]), .CG(seg2[0])
    );

    // ---------------- reference model ----------------
    localparam logic [6:0] SEGS [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                         7'h00, 7'h04, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

    int         n;           // edges since reset release (scan position)
    int         m;           // edges since last blink restart
    logic [3:0] sh [4];
    logic [3:0] dp [4];
    logic [1:0] padj;
    logic [10:0] exp1, exp2;

    function automatic logic [10:0] model_out(int ghost);
        int slot, idx;
        bit ph, sel;
        logic [3:0] a;
        logic [6:0] s;
        slot = n % R;
        idx  = (n / R) % 4;
        if (slot < ghost) return {4'b1111, 7'h7F};
        a   = ~(4'b0001 << idx);
        s   = SEGS[dp[idx]];
        ph  = ((m / B) % 2) == 1;
        sel = (adj_state == 2'b01 && idx >= 2) || (adj_state == 2'b10 && idx < 2);
        if (ph && sel && adj_state == padj) s = 7'h7F;
        return {a, s};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            exp1 = {4'b1111, 7'h7F};
            exp2 = {4'b1111, 7'h7F};
            n = 0; m = 0;
            for (int i = 0; i < 4; i++) begin sh[i] = 0; dp[i] = 0; end
            padj = adj_state;
        end else begin
            exp1 = model_out(G);
            exp2 = model_out(0);
            if (n % (4 * R) == 4 * R - 1) dp = sh;
            if (upd) begin
                sh[3] = min_tens; sh[2] = min_ones; sh[1] = sec_tens; sh[0] = sec_ones;
            end
            if (adj_state != padj) m = 0; else m++;
            padj = adj_state;
            n++;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] exv);
        total++;
        if (act !== exv) begin
            bad++;
            $display("FAIL %s t=%0t: got AN=%b seg=%h, expected AN=%b seg=%h",
                     nm, $time, act[10:7], act[6:0], exv[10:7], exv[6:0]);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exv);
        total++;
        if (act != exv) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exv);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_g2", {an1, seg1}, exp1);
            chk("model_g0", {an2, seg2}, exp2);
        end
    end

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_an(input logic [3:0] a);
        int k = 0;
        while (an1 !== a && k < 60) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (an1 !== a) begin
            bad++;
            $display("FAIL wait_an: AN=%b never reached %b", an1, a);
        end
    endtask

    task automatic load(input logic [3:0] d3, d2, d1, d0);
        min_tens = d3; min_ones = d2; sec_tens = d1; sec_ones = d0;
        upd = 1'b1;
        step(1);
        upd = 1'b0;
    endtask

    typedef struct { logic [3:0] dig; logic [10:0] exv; } vec_t;
    vec_t vecs [16];

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] pat [4];
        int be, vl, lb, cnt;

        for (int d = 0; d < 16; d++) begin
            vecs[d].dig = 4'(d);
            vecs[d].exv = {4'b1110, (d < 10) ? SEGS[d] : 7'h7F};
        end
        vecs[12].exv = {4'b1110, 7'h7F};   // code C: anode driven, blank
        pat[0] = 4'b1101; pat[1] = 4'b1011; pat[2] = 4'b0111; pat[3] = 4'b1110;

        reset = 1'b1; upd = 1'b0; adj_state = 2'b00;
        min_tens = 0; min_ones = 0; sec_tens = 0; sec_ones = 0;
        @(negedge clk);
        chk_en = 1;
        step(2);
        chk("reset_state", {an1, seg1}, {4'b1111, 7'h7F});
        reset = 1'b0;

        // Test 1: ghost interval then scan pattern.
        step(1);
        chk("slot0_c0", {an1, seg1}, {4'b1111, 7'h7F});
        chk("noghost_c0", {an2, seg2}, {4'b1110, 7'h01});
        step(1);
        chk("slot0_c1", {an1, seg1}, {4'b1111, 7'h7F});
        step(1);
        chk("slot0_c2", {an1, seg1}, {4'b1110, 7'h01});
        for (int k = 0; k < 4; k++) begin
            step(R);
            chk("scan_pat", {an1, seg1}, {pat[k], 7'h01});
        end

        // Test 2: mid-frame update held until frame wrap.
        step(R);
        load(4'd1, 4'd2, 4'd5, 4'd9);
        wait_an(4'b0111); chk("old_held", {an1, seg1}, {4'b0111, 7'h01});
        wait_an(4'b1110); chk("new_an0", {an1, seg1}, {4'b1110, 7'h04});
        wait_an(4'b1101); chk("new_an1", {an1, seg1}, {4'b1101, 7'h24});
        wait_an(4'b1011); chk("new_an2", {an1, seg1}, {4'b1011, 7'h12});
        wait_an(4'b0111); chk("new_an3", {an1, seg1}, {4'b0111, 7'h4F});

        // Test 3: update coincident with the commit edge.
        cnt = 0;
        while (n % (4 * R) != 4 * R - 1 && cnt < 40) begin step(1); cnt++; end
        load(4'd3, 4'd4, 4'd6, 4'd7);
        wait_an(4'b1110); chk("coinc_old0", {an1, seg1}, {4'b1110, 7'h04});
        wait_an(4'b0111); chk("coinc_old3", {an1, seg1}, {4'b0111, 7'h4F});
        wait_an(4'b1110); chk("coinc_new0", {an1, seg1}, {4'b1110, 7'h0F});
        wait_an(4'b0111); chk("coinc_new3", {an1, seg1}, {4'b0111, 7'h06});

        // Test 4: minutes blink, then switch to seconds mid-blank.
        adj_state = 2'b01;
        be = 0; vl = 0; lb = 0;
        for (int k = 1; k <= 100; k++) begin
            step(1);
            if (an1 == 4'b0111 || an1 == 4'b1011) begin
                if (k <= 65 && seg1 == 7'h7F) be++;
                if (k >= 66 && seg1 != 7'h7F) vl++;
            end
            if ((an1 == 4'b1110 || an1 == 4'b1101) && seg1 == 7'h7F) lb++;
        end
        chk_int("blink_visible_phase", be, 0);
        chk_int("blink_blank_phase", vl, 0);
        chk_int("blink_sec_untouched", lb, 0);
        adj_state = 2'b10;
        be = 0;
        for (int k = 0; k < 60; k++) begin
            step(1);
            if (an1 != 4'b1111 && seg1 == 7'h7F) be++;
        end
        chk_int("blink_switch_visible", be, 0);

        // Test 5: decode table, including non-BCD codes.
        adj_state = 2'b00;
        for (int i = 0; i < 16; i++) begin
            load(vecs[i].dig, vecs[i].dig, vecs[i].dig, vecs[i].dig);
            step(40);
            wait_an(4'b1110);
            chk("decode", {an1, seg1}, vecs[i].exv);
        end

        // Test 6: reset mid-frame with committed digits.
        load(4'd8, 4'd8, 4'd8, 4'd8);
        step(40);
        wait_an(4'b1011);
        chk("pre_reset", {an1, seg1}, {4'b1011, 7'h00});
        reset = 1'b1;
        step(1);
        chk("reset_mid", {an1, seg1}, {4'b1111, 7'h7F});
        chk("reset_mid_ng", {an2, seg2}, {4'b1111, 7'h7F});
        step(2);
        reset = 1'b0;
        wait_an(4'b1110); chk("post_reset0", {an1, seg1}, {4'b1110, 7'h01});
        wait_an(4'b0111); chk("post_reset3", {an1, seg1}, {4'b0111, 7'h01});

        // Randomized run against the model.
        for (int k = 0; k < 3000; k++) begin
            upd = ($urandom_range(7) == 0);
            min_tens = 4'($urandom_range(15)); min_ones = 4'($urandom_range(15));
            sec_tens = 4'($urandom_range(15)); sec_ones = 4'($urandom_range(15));
            if ($urandom_range(199) == 0) adj_state = 2'($urandom_range(3));
            reset = ($urandom_range(499) == 0);
            step(1);
        end
        reset = 1'b0; upd = 1'b0;
        step(2);
        chk_en = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
